// File: rtl/wb_csr_pkg.sv
// wb_csr_pkg: shared FSM encoding and sizing helper for the Wishbone CSR slave
package wb_csr_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_e;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/wb_csr_regbank.sv
// wb_csr_regbank: register array with byte-lane writes, read mux and write pulses
module wb_csr_regbank import wb_csr_pkg::*; #(
    parameter int DATA_W = 32,
    parameter int NUM_REGS = 8,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    localparam int SEL_W = DATA_W / 8,
    localparam int IDX_W = NUM_REGS > 1 ? clog2(NUM_REGS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [IDX_W-1:0]           idx,
    input  logic [SEL_W-1:0]           sel,
    input  logic [DATA_W-1:0]          wdat,
    output logic [DATA_W-1:0]          rdat,
    output logic [NUM_REGS*DATA_W-1:0] reg_q,
    output logic [NUM_REGS-1:0]        reg_wr_pulse
);
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] pulse_q, pulse_d;
    always_comb begin
        regs_d = regs_q;
        pulse_d = '0;
        if (wr_en) begin
            for (int b = 0; b < SEL_W; b++)
                if (sel[b]) regs_d[idx][b*8 +: 8] = wdat[b*8 +: 8];
            pulse_d[idx] = |sel;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: RESET_VAL};
            pulse_q <= '0;
        end else begin
            regs_q <= regs_d;
            pulse_q <= pulse_d;
        end
    end
    // sampled before this edge's write, so a transfer sees the pre-write value
    assign rdat = regs_q[idx];
    assign reg_wr_pulse = pulse_q;
    for (genvar i = 0; i < NUM_REGS; i++) assign reg_q[i*DATA_W +: DATA_W] = regs_q[i];
endmodule

// File: rtl/wb_csr_slave.sv
// wb_csr_slave: Wishbone classic CSR slave with configurable wait states
module wb_csr_slave import wb_csr_pkg::*; #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int NUM_REGS = 8,
    parameter int WAIT_CYCLES = 0,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    localparam int SEL_W = DATA_W / 8,
    localparam int IDX_W = NUM_REGS > 1 ? clog2(NUM_REGS) : 1
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic [ADDR_W-1:0]          wb_adr_i,
    input  logic [DATA_W-1:0]          wb_dat_i,
    input  logic [SEL_W-1:0]           wb_sel_i,
    input  logic                       wb_we_i,
    input  logic                       wb_cyc_i,
    input  logic                       wb_stb_i,
    output logic [DATA_W-1:0]          wb_dat_o,
    output logic                       wb_ack_o,
    output logic                       wb_err_o,
    output logic [NUM_REGS*DATA_W-1:0] reg_q,
    output logic [NUM_REGS-1:0]        reg_wr_pulse
);
    state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic we_q, we_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [DATA_W-1:0] dat_q, dat_d, rdat_q, rdat_d, rdat;
    logic ack_q, ack_d, err_q, err_d, in_range;
    assign in_range = 32'(adr_q) < NUM_REGS;
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        adr_d = adr_q;
        we_d = we_q;
        sel_d = sel_q;
        dat_d = dat_q;
        ack_d = state_q == RESP && in_range;
        err_d = state_q == RESP && !in_range;
        rdat_d = ack_d ? rdat : '0;
        if (state_q == IDLE && wb_cyc_i && wb_stb_i) begin
            adr_d = wb_adr_i;
            we_d = wb_we_i;
            sel_d = wb_sel_i;
            dat_d = wb_dat_i;
            cnt_d = 4'(WAIT_CYCLES - 1);
            state_d = WAIT_CYCLES == 0 ? RESP : WAIT;
        end
        if (state_q == WAIT) begin
            cnt_d = cnt_q - 4'd1;
            state_d = !wb_cyc_i ? IDLE : cnt_q == 4'd0 ? RESP : WAIT;
        end
        if (state_q == RESP) state_d = IDLE;
    end
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            adr_q <= '0;
            we_q <= 1'b0;
            sel_q <= '0;
            dat_q <= '0;
            ack_q <= 1'b0;
            err_q <= 1'b0;
            rdat_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            adr_q <= adr_d;
            we_q <= we_d;
            sel_q <= sel_d;
            dat_q <= dat_d;
            ack_q <= ack_d;
            err_q <= err_d;
            rdat_q <= rdat_d;
        end
    end
    wb_csr_regbank #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .RESET_VAL(RESET_VAL)) u_bank (
        .clk(sys_clk),
        .rst(sys_rst),
        .wr_en(ack_d && we_q),
        .idx(adr_q[IDX_W-1:0]),
        .sel(sel_q),
        .wdat(dat_q),
        .rdat(rdat),
        .reg_q(reg_q),
        .reg_wr_pulse(reg_wr_pulse)
    );
    assign wb_dat_o = rdat_q;
    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
endmodule

// File: tb/tb_wb_csr_slave.sv
// tb_wb_csr_slave: checks a zero-wait and a three-wait instance against an array model
module tb_wb_csr_slave;
    localparam logic [31:0] RV = 32'hCAFE_0000;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    logic [7:0] adr [2];
    logic [31:0] dat_i [2];
    logic [3:0] sel [2];
    logic we [2], cyc [2], stb [2];
    logic [31:0] dat_o [2];
    logic ack [2], err [2];
    logic [255:0] regq [2];
    logic [7:0] pulse [2];
    int wc [2] = '{0, 3};
    int checks = 0;
    int fails = 0;
    logic [31:0] m [2][8];
    typedef struct {
        logic w;
        logic [7:0] a;
        logic [31:0] d;
        logic [3:0] s;
        logic [31:0] rd;
        logic e;
    } vec_t;
    vec_t tv [10];
    wb_csr_slave #(.ADDR_W(8), .DATA_W(32), .NUM_REGS(8), .WAIT_CYCLES(0), .RESET_VAL(RV)) u0 (
        .sys_clk(clk), .sys_rst(rst), .wb_adr_i(adr[0]), .wb_dat_i(dat_i[0]), .wb_sel_i(sel[0]),
        .wb_we_i(we[0]), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_dat_o(dat_o[0]),
        .wb_ack_o(ack[0]), .wb_err_o(err[0]), .reg_q(regq[0]), .reg_wr_pulse(pulse[0])
    );
    wb_csr_slave #(.ADDR_W(8), .DATA_W(32), .NUM_REGS(8), .WAIT_CYCLES(3), .RESET_VAL(RV)) u3 (
        .sys_clk(clk), .sys_rst(rst), .wb_adr_i(adr[1]), .wb_dat_i(dat_i[1]), .wb_sel_i(sel[1]),
        .wb_we_i(we[1]), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_dat_o(dat_o[1]),
        .wb_ack_o(ack[1]), .wb_err_o(err[1]), .reg_q(regq[1]), .reg_wr_pulse(pulse[1])
    );
    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    function automatic logic [255:0] flat(input int k);
        logic [255:0] f;
        for (int i = 0; i < 8; i++) f[i*32 +: 32] = m[k][i];
        return f;
    endfunction
    task automatic quiet(input int k, input string name);
        chk({name, "_ack"}, ack[k], 0);
        chk({name, "_err"}, err[k], 0);
        chk({name, "_dat"}, dat_o[k], 0);
        chk({name, "_pulse"}, pulse[k], 0);
        chk({name, "_regs"}, regq[k], flat(k));
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic xfer(input int k, input logic w, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output logic e);
        int n;
        logic ok;
        logic [31:0] old, nw;
        ok = a < 8;
        old = ok ? m[k][a[2:0]] : 32'h0;
        nw = old;
        for (int b = 0; b < 4; b++) if (s[b]) nw[b*8 +: 8] = d[b*8 +: 8];
        we[k] = w; adr[k] = a; dat_i[k] = d; sel[k] = s; cyc[k] = 1'b1; stb[k] = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!ack[k] && !err[k] && n < 40);
        cyc[k] = 1'b0; stb[k] = 1'b0;
        rd = dat_o[k];
        e = err[k];
        chk("latency", n, wc[k] + 2);
        chk("ack", ack[k], ok);
        chk("err", err[k], !ok);
        if (!w || !ok) chk("rdata", dat_o[k], ok ? old : 32'h0);
        if (ok && w) m[k][a[2:0]] = nw;
        chk("regs", regq[k], flat(k));
        chk("pulse", pulse[k], (ok && w && s != 0) ? (8'd1 << a[2:0]) : 8'd0);
        step();
        quiet(k, "post");
    endtask
    initial begin
        logic [31:0] rd;
        logic e;
        tv[0] = '{1'b1, 8'd3, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0};
        tv[1] = '{1'b0, 8'd3, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0};
        tv[2] = '{1'b1, 8'd1, 32'h11223344, 4'hF, 32'h0, 1'b0};
        tv[3] = '{1'b1, 8'd1, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0};
        tv[4] = '{1'b0, 8'd1, 32'h0, 4'hF, 32'h11BB33DD, 1'b0};
        tv[5] = '{1'b1, 8'd1, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0};
        tv[6] = '{1'b0, 8'd1, 32'h0, 4'hF, 32'h11BB33DD, 1'b0};
        tv[7] = '{1'b1, 8'd8, 32'h12345678, 4'hF, 32'h0, 1'b1};
        tv[8] = '{1'b0, 8'd200, 32'h0, 4'hF, 32'h0, 1'b1};
        tv[9] = '{1'b0, 8'd0, 32'h0, 4'hF, RV, 1'b0};
        for (int k = 0; k < 2; k++) begin
            adr[k] = 0; dat_i[k] = 0; sel[k] = 0; we[k] = 0; cyc[k] = 0; stb[k] = 0;
            for (int i = 0; i < 8; i++) m[k][i] = RV;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            for (int k = 0; k < 2; k++) quiet(k, "reset");
        end
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 10; i++) begin
                xfer(k, tv[i].w, tv[i].a, tv[i].d, tv[i].s, rd, e);
                chk("tv_err", e, tv[i].e);
                if (!tv[i].w) chk("tv_rdata", rd, tv[i].rd);
            end
        we[1] = 1'b0; adr[1] = 8'd0; sel[1] = 4'hF; cyc[1] = 1'b1; stb[1] = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            step();
            chk("b2b_ack", ack[1], i % 5 == 0);
            chk("b2b_err", err[1], 0);
            chk("b2b_dat", dat_o[1], i % 5 == 0 ? m[1][0] : 32'h0);
        end
        cyc[1] = 1'b0; stb[1] = 1'b0;
        step();
        quiet(1, "b2b_end");
        we[1] = 1'b1; adr[1] = 8'd2; dat_i[1] = 32'h12345678; sel[1] = 4'hF; cyc[1] = 1'b1; stb[1] = 1'b1;
        step();
        step();
        cyc[1] = 1'b0; stb[1] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            quiet(1, "abort");
        end
        xfer(1, 1'b0, 8'd2, 32'h0, 4'hF, rd, e);
        we[1] = 1'b1; adr[1] = 8'd4; dat_i[1] = 32'h00000055; sel[1] = 4'hF; cyc[1] = 1'b1; stb[1] = 1'b1;
        step();
        step();
        rst = 1'b1; cyc[1] = 1'b0; stb[1] = 1'b0;
        step();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) for (int i = 0; i < 8; i++) m[k][i] = RV;
        for (int c = 0; c < 6; c++) begin
            step();
            for (int k = 0; k < 2; k++) quiet(k, "rst_wait");
        end
        xfer(1, 1'b1, 8'd4, 32'h0BADF00D, 4'hF, rd, e);
        xfer(1, 1'b0, 8'd4, 32'h0, 4'hF, rd, e);
        chk("after_rst_rd", rd, 32'h0BADF00D);
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 40; i++)
                xfer(k, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 11)), $urandom,
                     4'($urandom_range(0, 15)), rd, e);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
